// File: rtl/native_in_wr_sched.sv
// -----------------------------------------------------------------------------
// native_in_wr_sched
//   Write-burst scheduler for the native video input path. It counts beats
//   that have entered the downstream write FIFO but have not been requested
//   yet. It issues full-length or flush-length burst requests to the AXI write
//   master, keeping one burst outstanding at a time. Each burst address is the
//   frame buffer base plus the bytes already requested in the current frame.
//   Frame buffers are used in rotation across a ring of FRAME_NUM entries.
//
// Ports
//   clock, rst_n          system clock / asynchronous active-low reset
//   enable                scheduler runs while high
//   base_addr             byte address of frame buffer 0
//   frame_stride          byte distance between consecutive frame buffers
//   falign/lalign/ealign  frame-start / line-end / frame-end pulses
//   in_vld                one beat entered the write FIFO this cycle
//   burst_req/addr/len    burst request to the write master (held until ack)
//   burst_ack             master accepted the request
//   burst_done            master finished the last accepted burst
//   frame_idx             frame buffer currently being written
//   frame_done            pulse: last burst of a frame completed
//   frame_err             pulse: falign arrived mid-frame
//   overflow              sticky: pending beats exceeded FIFO_DEPTH
// -----------------------------------------------------------------------------
module native_in_wr_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LEN      = 64,
    parameter int BYTES_PER_BEAT = 4,
    parameter int FRAME_NUM      = 3,
    parameter int FIFO_DEPTH     = 512,
    parameter     MODE           = "ONCE"
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] frame_stride,
    input  logic                  falign,
    input  logic                  lalign,
    input  logic                  ealign,
    input  logic                  in_vld,
    output logic                  burst_req,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic [8:0]            burst_len,
    input  logic                  burst_ack,
    input  logic                  burst_done,
    output logic [1:0]            frame_idx,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_FRAME = 3'd1;
    localparam logic [2:0] COLLECT    = 3'd2;
    localparam logic [2:0] REQ        = 3'd3;
    localparam logic [2:0] WAIT_DONE  = 3'd4;

    localparam bit        LINE_MODE = (MODE == "LINE");
    localparam logic [15:0] FULL_LEN = 16'(BURST_LEN);
    localparam logic [15:0] OVF_LVL  = 16'(FIFO_DEPTH);
    localparam logic [1:0]  IDX_LAST = 2'(FRAME_NUM - 1);

    logic [2:0]            state, state_nxt;
    logic [15:0]           pending, pend_upd;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  flush_line;  // line-end flush request
    logic                  flush_eof;   // frame-end flush request
    logic                  restart;     // falign seen while a burst was in flight
    logic                  cur_flush;   // outstanding burst was a flush burst
    logic                  cur_eof;     // ... and it drained the frame-end flush

    logic                  active, acc;
    logic [15:0]           pend_inc, pend_dec;
    logic [ADDR_WIDTH-1:0] frame_base, len_bytes;
    logic [1:0]            idx_nxt;

    // decision strobes from the next-state logic
    logic                  do_start, do_issue, issue_flush, issue_eof;
    logic [8:0]            issue_len;
    logic                  set_err, set_done, set_restart, clr_line;

    assign active     = (state == COLLECT) || (state == REQ) || (state == WAIT_DONE);
    assign acc        = burst_req & burst_ack;
    assign pend_inc   = {15'd0, active & in_vld};
    assign pend_dec   = acc ? {7'd0, burst_len} : 16'd0;
    // arrival and acceptance may land in the same cycle; both apply
    assign pend_upd   = pending + pend_inc - pend_dec;
    assign frame_base = base_addr + ADDR_WIDTH'(frame_idx) * frame_stride;
    assign len_bytes  = ADDR_WIDTH'(burst_len) * ADDR_WIDTH'(BYTES_PER_BEAT);
    assign idx_nxt    = (frame_idx == IDX_LAST) ? 2'd0 : frame_idx + 2'd1;

    always_comb begin
        state_nxt   = state;
        do_start    = 1'b0;
        do_issue    = 1'b0;
        issue_len   = 9'(BURST_LEN);
        issue_flush = 1'b0;
        issue_eof   = 1'b0;
        set_err     = 1'b0;
        set_done    = 1'b0;
        set_restart = 1'b0;
        clr_line    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!enable)     state_nxt = IDLE;
                else if (falign) do_start  = 1'b1;
            end
            COLLECT: begin
                if (falign) begin
                    // nothing in flight, so the new frame can start right away
                    set_err  = 1'b1;
                    do_start = 1'b1;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end else if (pending >= FULL_LEN) begin
                    do_issue = 1'b1;
                end else if ((flush_line || flush_eof) && pending != 16'd0) begin
                    do_issue    = 1'b1;
                    issue_len   = pending[8:0];
                    issue_flush = 1'b1;
                    issue_eof   = flush_eof;
                end else if (flush_eof) begin
                    set_done  = 1'b1;
                    state_nxt = WAIT_FRAME;
                end else if (flush_line) begin
                    // line ended exactly on a burst boundary: nothing to flush
                    clr_line = 1'b1;
                end
            end
            REQ: begin
                set_err     = falign;
                set_restart = falign;
                if (acc) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                set_err     = falign;
                set_restart = falign;
                if (burst_done) begin
                    if (!enable)                        state_nxt = IDLE;
                    else if (restart || falign)         do_start  = 1'b1;
                    else if (cur_eof && pending == 16'd0) begin
                        set_done  = 1'b1;
                        state_nxt = WAIT_FRAME;
                    end else                            state_nxt = COLLECT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (do_issue) state_nxt = REQ;
        if (do_start) state_nxt = COLLECT;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 16'd0;
            offset     <= '0;
            flush_line <= 1'b0;
            flush_eof  <= 1'b0;
            restart    <= 1'b0;
            cur_flush  <= 1'b0;
            cur_eof    <= 1'b0;
            burst_req  <= 1'b0;
            burst_addr <= '0;
            burst_len  <= 9'd0;
            frame_idx  <= IDX_LAST;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= set_done;
            frame_err  <= set_err;
            pending    <= pend_upd;

            if (acc) begin
                offset    <= offset + len_bytes;
                burst_req <= 1'b0;
            end
            if (pending > OVF_LVL) overflow <= 1'b1;

            // flush requests from the port; a frame-end flag raised after the
            // flush burst was chosen survives that burst's acceptance
            if (acc && cur_flush) begin
                flush_line <= 1'b0;
                if (cur_eof) flush_eof <= 1'b0;
            end
            if (clr_line) flush_line <= 1'b0;
            if (active && lalign && LINE_MODE) flush_line <= 1'b1;
            if (active && ealign) flush_eof <= 1'b1;

            if (set_restart) restart <= 1'b1;
            if (state_nxt == IDLE) restart <= 1'b0;

            if (do_issue) begin
                burst_req  <= 1'b1;
                burst_len  <= issue_len;
                burst_addr <= frame_base + offset;
                cur_flush  <= issue_flush;
                cur_eof    <= issue_eof;
            end

            // new frame: beats of any aborted frame are dropped here
            if (do_start) begin
                pending    <= 16'd0;
                offset     <= '0;
                frame_idx  <= idx_nxt;
                overflow   <= 1'b0;
                flush_line <= 1'b0;
                flush_eof  <= 1'b0;
                restart    <= 1'b0;
                cur_flush  <= 1'b0;
                cur_eof    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_native_in_wr_sched.sv
module tb_native_in_wr_sched;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  len;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [31:0] base, stride;
    logic        fa, la, ea, vld;

    logic        req_a, ack_a, done_a, fd_a, fe_a, ov_a;
    logic [31:0] addr_a;
    logic [8:0]  len_a;
    logic [1:0]  idx_a;
    logic        req_b, ack_b, done_b, fd_b, fe_b, ov_b;
    logic [31:0] addr_b;
    logic [8:0]  len_b;
    logic [1:0]  idx_b;

    int     n_cmp = 0;
    int     n_err = 0;
    int     ferr_a = 0;
    int     ferr_b = 0;
    bit     man_a = 1'b0;
    burst_t qa[$];
    burst_t qb[$];

    always #5 clk = ~clk;

    // ONCE mode, 3-buffer ring, shallow FIFO for the overflow case
    native_in_wr_sched #(.FRAME_NUM(3), .FIFO_DEPTH(128), .MODE("ONCE")) u_a (
        .clock(clk), .rst_n(rst_n), .enable(en_a), .base_addr(base),
        .frame_stride(stride), .falign(fa), .lalign(la), .ealign(ea),
        .in_vld(vld), .burst_req(req_a), .burst_addr(addr_a),
        .burst_len(len_a), .burst_ack(ack_a), .burst_done(done_a),
        .frame_idx(idx_a), .frame_done(fd_a), .frame_err(fe_a),
        .overflow(ov_a));

    // LINE mode, single buffer
    native_in_wr_sched #(.FRAME_NUM(1), .MODE("LINE")) u_b (
        .clock(clk), .rst_n(rst_n), .enable(en_b), .base_addr(base),
        .frame_stride(stride), .falign(fa), .lalign(la), .ealign(ea),
        .in_vld(vld), .burst_req(req_b), .burst_addr(addr_b),
        .burst_len(len_b), .burst_ack(ack_b), .burst_done(done_b),
        .frame_idx(idx_b), .frame_done(fd_b), .frame_err(fe_b),
        .overflow(ov_b));

    always @(negedge clk) begin
        if (fe_a) ferr_a <= ferr_a + 1;
        if (fe_b) ferr_b <= ferr_b + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input bit sel, input logic [31:0] a, input logic [8:0] l);
        burst_t e;
        if ((sel ? qb.size() : qa.size()) == 0) begin
            chk(sel ? "b_unexpected_burst" : "a_unexpected_burst", 64'(a), 64'hffff_ffff);
            return;
        end
        e = sel ? qb.pop_front() : qa.pop_front();
        chk(sel ? "b_addr" : "a_addr", 64'(a), 64'(e.addr));
        chk(sel ? "b_len" : "a_len", 64'(l), 64'(e.len));
    endtask

    // expected bursts of one frame: line mode flushes per line, else per frame
    task automatic push_frame(input bit sel, input int idx, input int lines, input int n);
        int off = 0;
        int chunks = sel ? lines : 1;
        int per = sel ? n : lines * n;
        for (int c = 0; c < chunks; c++) begin
            int left = per;
            while (left > 0) begin
                burst_t e;
                int l = (left >= 64) ? 64 : left;
                e.addr = base + 32'(idx) * stride + 32'(off);
                e.len  = 9'(l);
                if (sel) qb.push_back(e); else qa.push_back(e);
                off  += l * 4;
                left -= l;
            end
        end
    endtask

    // bus master models: ack on first req cycle, done a few cycles later
    initial begin
        ack_a = 1'b0; done_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (req_a && !man_a) begin
                sb_pop(0, addr_a, len_a);
                ack_a = 1'b1;
                @(posedge clk); #1;
                ack_a = 1'b0;
                repeat (3) @(posedge clk);
                #1 done_a = 1'b1;
                @(posedge clk); #1;
                done_a = 1'b0;
            end
        end
    end

    initial begin
        ack_b = 1'b0; done_b = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (req_b) begin
                sb_pop(1, addr_b, len_b);
                ack_b = 1'b1;
                @(posedge clk); #1;
                ack_b = 1'b0;
                repeat (3) @(posedge clk);
                #1 done_b = 1'b1;
                @(posedge clk); #1;
                done_b = 1'b0;
            end
        end
    end

    // stimulus tasks start and end at #1 after a rising edge
    task automatic pulse_fa();
        fa = 1'b1; @(posedge clk); #1; fa = 1'b0;
    endtask

    task automatic pulse_ea();
        ea = 1'b1; @(posedge clk); #1; ea = 1'b0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            vld = 1'b1; @(posedge clk); #1;
        end
        vld = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int n);
        pulse_fa();
        @(posedge clk); #1;
        for (int l = 0; l < lines; l++) begin
            beats(n);
            la = 1'b1; @(posedge clk); #1; la = 1'b0;
            repeat (12) @(posedge clk);
            #1;
        end
        pulse_ea();
    endtask

    task automatic wait_fd(input bit sel, input int idx);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (sel ? fd_b : fd_a) begin
                seen = 1'b1;
                break;
            end
        end
        chk(sel ? "b_frame_done_seen" : "a_frame_done_seen", 64'(seen), 64'd1);
        chk(sel ? "b_frame_idx" : "a_frame_idx", 64'(sel ? idx_b : idx_a), 64'(idx));
        chk(sel ? "b_sb_empty" : "a_sb_empty", 64'(sel ? qb.size() : qa.size()), 64'd0);
    endtask

    initial begin
        int fe0;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        fa = 1'b0; la = 1'b0; ea = 1'b0; vld = 1'b0;
        base = 32'h1000_0000; stride = 32'h0080_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(req_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_len", 64'(len_a), 64'd0);
        chk("rst_idx_a", 64'(idx_a), 64'd2);
        chk("rst_idx_b", 64'(idx_b), 64'd0);
        chk("rst_done_err_ovf", 64'({fd_a, fe_a, ov_a}), 64'd0);
        rst_n = 1'b1;
        en_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 4 x 64 beats -> four full bursts into buffer 0
        push_frame(0, 0, 4, 64); send_frame(4, 64); wait_fd(0, 0);
        // 2 x 100 beats in ONCE mode -> 64, 64, 64, 8
        push_frame(0, 1, 2, 100); send_frame(2, 100); wait_fd(0, 1);
        // ring walk and wrap
        push_frame(0, 2, 1, 64); send_frame(1, 64); wait_fd(0, 2);
        push_frame(0, 0, 1, 64); send_frame(1, 64); wait_fd(0, 0);

        // falign after 30 beats: no partial burst, two buffer advances
        fe0 = ferr_a;
        pulse_fa();
        chk("abort_idx_first", 64'(idx_a), 64'd1);
        beats(30);
        repeat (3) @(posedge clk);
        #1;
        push_frame(0, 2, 1, 64);
        pulse_fa();
        @(posedge clk); #1;
        chk("abort_pending_clr", 64'(u_a.pending), 64'd0);
        chk("abort_idx_restart", 64'(idx_a), 64'd2);
        beats(64);
        pulse_ea();
        wait_fd(0, 2);
        chk("abort_err_pulses", 64'(ferr_a - fe0), 64'd1);

        // ack withheld: overflow, then ack with a simultaneous beat
        man_a = 1'b1;
        push_frame(0, 0, 1, 201);
        pulse_fa();
        @(posedge clk); #1;
        beats(200);
        chk("ovf_pending", 64'(u_a.pending), 64'd200);
        chk("ovf_set", 64'(ov_a), 64'd1);
        chk("ovf_req_held", 64'(req_a), 64'd1);
        sb_pop(0, addr_a, len_a);
        vld = 1'b1; ack_a = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; ack_a = 1'b0;
        chk("ack_with_beat_pending", 64'(u_a.pending), 64'd137);
        repeat (2) @(posedge clk);
        #1 done_a = 1'b1;
        @(posedge clk); #1;
        done_a = 1'b0;
        man_a = 1'b0;
        pulse_ea();
        wait_fd(0, 0);
        chk("ovf_sticky", 64'(ov_a), 64'd1);
        push_frame(0, 1, 1, 64);
        pulse_fa();
        chk("ovf_clr_on_falign", 64'(ov_a), 64'd0);
        @(posedge clk); #1;
        beats(64);
        pulse_ea();
        wait_fd(0, 1);

        // LINE mode instance: per-line flush, single buffer stays at 0
        en_a = 1'b0; en_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_frame(1, 0, 2, 100); send_frame(2, 100); wait_fd(1, 0);
        push_frame(1, 0, 2, 100); send_frame(2, 100); wait_fd(1, 0);
        chk("b_no_err_ovf", 64'({fe_b, ov_b}), 64'd0);
        chk("b_err_pulses", 64'(ferr_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global guard so the run always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
